sh7604_div_initiator: RTL and testbench
=======================================

SH7604_DIV_INITIATOR -- requirements
Module: sh7604_div_initiator

Interface
REQ-001 Parameter DIVU_BASE, default 32'hFFFFFF00, SHALL be the divider register block base address.
REQ-002 Parameter TMO_CYC, default 8'd255, SHALL be the per-transaction timeout in enabled CE_R cycles (used only with DIVINIT_TIMEOUT_EN).
REQ-003 CLK  in  1  clock; RST_N  in  1  reset, asynchronous, active-low.
REQ-004 CE_R  in  1  rising-phase enable; CE_F  in  1  falling-phase enable; EN  in  1  block enable.
REQ-005 CMD_VALID  in  1  command offered; CMD_READY  out  1  command accepted when high with CMD_VALID at an EN&&CE_R edge.
REQ-006 CMD_DIV64  in  1  64/32 divide when 1, 32/32 when 0; CMD_DVSR  in  32  divisor; CMD_DVDH  in  32  dividend high (ignored for 32/32); CMD_DVDL  in  32  dividend low.
REQ-007 RES_VALID  out  1  result strobe; RES_Q  out  32  quotient; RES_R  out  32  remainder; RES_OVF  out  1  overflow flag; RES_ERR  out  1  timeout abort.
REQ-008 IBUS_A  out  32  address; IBUS_DO  out  32  write data; IBUS_BA  out  4  byte enables; IBUS_WE  out  1  write; IBUS_REQ  out  1  request.
REQ-009 IBUS_DI  in  32  read data; IBUS_BUSY  in  1  responder stall.

Function
REQ-010 All state and outputs SHALL update only on CLK edges with EN&&CE_R; CE_F is unused except as documented in REQ-014.
REQ-011 States SHALL be: IDLE, W_DVCR, W_DVSR, W_DVDH, W_DVDL, W_DVDNT, R_DVDL, R_DVDH, R_DVCR, DONE.
REQ-012 Sequence 32/32: IDLE -> W_DVCR(+08, data 0) -> W_DVSR(+00) -> W_DVDNT(+04, CMD_DVDL) -> R_DVDL(+14) -> R_DVDH(+10) -> R_DVCR(+08) -> DONE -> IDLE.
REQ-013 Sequence 64/32: as REQ-012 but W_DVDNT replaced by W_DVDH(+10, CMD_DVDH) then W_DVDL(+14, CMD_DVDL).
REQ-014 In every bus state IBUS_REQ=1, IBUS_BA=4'hF, IBUS_A/IBUS_DO/IBUS_WE SHALL be registered and held stable until completion; the responder's read data is valid from the preceding CE_F.
REQ-015 A transaction SHALL complete at an EN&&CE_R edge where IBUS_REQ=1 and IBUS_BUSY=0; minimum one CE_R cycle per transaction; next state's request driven from the same edge (back-to-back, no idle gap).
REQ-016 Reads SHALL capture IBUS_DI at completion: R_DVDL -> RES_Q, R_DVDH -> RES_R, R_DVCR -> RES_OVF=IBUS_DI[0].
REQ-017 In IDLE and DONE, IBUS_REQ=0, IBUS_WE=0, IBUS_A=0.
REQ-018 CMD_READY SHALL be 1 only in IDLE; command fields SHALL be latched at acceptance, later CMD_* changes ignored.
REQ-019 DONE SHALL assert RES_VALID for exactly one enabled CE_R period; RES_Q/RES_R/RES_OVF/RES_ERR SHALL hold until the next DONE.
REQ-020 Divisor zero and overflow SHALL be passed to the divider unchanged; the result reports whatever the divider returns, with no local check.
REQ-021 EN=0 SHALL freeze all state and outputs, including a held IBUS_REQ.

Reset
REQ-022 RST_N low SHALL asynchronously force IDLE, with IBUS_REQ=0, IBUS_WE=0, IBUS_A=0, IBUS_DO=0, IBUS_BA=0, CMD_READY=1 after release, and RES_* all 0, including mid-transaction.

Configuration
REQ-023 With DIVINIT_TIMEOUT_EN defined, a counter SHALL clear on each new bus state and increment per enabled CE_R cycle with IBUS_BUSY=1.
REQ-024 With DIVINIT_TIMEOUT_EN defined, reaching TMO_CYC SHALL drop IBUS_REQ, set RES_ERR=1, and go to DONE.
REQ-025 Without DIVINIT_TIMEOUT_EN, the block SHALL wait indefinitely, RES_ERR SHALL be constant 0, and no counter logic SHALL exist.

Verification
REQ-026 32/32, DVSR=7, DVDL=100 -> bus order FFFFFF08,00,04,14,10,08; RES_Q=14, RES_R=2, RES_OVF=0, one RES_VALID pulse.
REQ-027 32/32, DVSR=7, DVDL=-100 -> RES_Q=32'hFFFFFFF2, RES_R=32'hFFFFFFFE, RES_OVF=0.
REQ-028 64/32, DVDH=1, DVDL=0, DVSR=2 -> writes to +10 then +14; RES_OVF=1.
REQ-029 Responder holds IBUS_BUSY=1 for 10 CE_R cycles during R_DVDL -> IBUS_A/IBUS_REQ stable throughout, no state advance, then normal completion.
REQ-030 RST_N pulsed during W_DVSR -> IBUS_REQ=0 immediately, IDLE, no RES_VALID.
REQ-031 With DIVINIT_TIMEOUT_EN, IBUS_BUSY stuck at 1 -> after 255 cycles IBUS_REQ=0, RES_ERR=1, RES_VALID pulse, CMD_READY=1.

Source files
------------

// File: rtl/sh7604_div_initiator_if.sv
// Internal-bus port bundle between the divide initiator and the DIVU register responder.
// The master modport is the initiator side; the slave modport is the responder side.
interface sh7604_div_initiator_if;
  logic [31:0] IBUS_A;
  logic [31:0] IBUS_DO;
  logic [3:0]  IBUS_BA;
  logic        IBUS_WE;
  logic        IBUS_REQ;
  logic [31:0] IBUS_DI;
  logic        IBUS_BUSY;

  modport master (
    output IBUS_A,
    output IBUS_DO,
    output IBUS_BA,
    output IBUS_WE,
    output IBUS_REQ,
    input  IBUS_DI,
    input  IBUS_BUSY
  );

  modport slave (
    input  IBUS_A,
    input  IBUS_DO,
    input  IBUS_BA,
    input  IBUS_WE,
    input  IBUS_REQ,
    output IBUS_DI,
    output IBUS_BUSY
  );
endinterface

// File: rtl/sh7604_div_initiator.sv
// Drives one 32/32 or 64/32 divide through the SH7604 DIVU registers and returns Q/R/OVF.
// Define DIVINIT_TIMEOUT_EN to add a per-transaction busy timeout that aborts with RES_ERR.
module sh7604_div_initiator #(
  parameter logic [31:0] DIVU_BASE = 32'hFFFFFF00,
  parameter logic [7:0]  TMO_CYC   = 8'd255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic        EN,

  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_DIV64,
  input  logic [31:0] CMD_DVSR,
  input  logic [31:0] CMD_DVDH,
  input  logic [31:0] CMD_DVDL,

  output logic        RES_VALID,
  output logic [31:0] RES_Q,
  output logic [31:0] RES_R,
  output logic        RES_OVF,
  output logic        RES_ERR,

  sh7604_div_initiator_if.master ibus
);

  typedef enum logic [3:0] {
    StIdle,
    StWDvcr,
    StWDvsr,
    StWDvdh,
    StWDvdl,
    StWDvdnt,
    StRDvdl,
    StRDvdh,
    StRDvcr,
    StDone
  } state_e;

  localparam logic [7:0] OffDvsr  = 8'h00;
  localparam logic [7:0] OffDvdnt = 8'h04;
  localparam logic [7:0] OffDvcr  = 8'h08;
  localparam logic [7:0] OffDvdh  = 8'h10;
  localparam logic [7:0] OffDvdl  = 8'h14;

  state_e      state_q, state_d;
  logic        div64_q, div64_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [31:0] dvdh_q, dvdh_d;
  logic [31:0] dvdl_q, dvdl_d;
  logic [31:0] stage_quot_q, stage_quot_d;
  logic [31:0] stage_rem_q, stage_rem_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic        ovf_q, ovf_d;

  logic [31:0] ibus_a_q, ibus_a_d;
  logic [31:0] ibus_do_q, ibus_do_d;
  logic [3:0]  ibus_ba_q, ibus_ba_d;
  logic        ibus_we_q, ibus_we_d;
  logic        ibus_req_q, ibus_req_d;
  logic [7:0]  off_d;

  logic        step;
  logic        xfer_done;

  // CE_F only marks when the responder presents read data; no local state uses it.
  logic        unused_ce_f;
  assign unused_ce_f = CE_F;

`ifdef DIVINIT_TIMEOUT_EN
  logic [7:0]  tmo_q, tmo_d;
  logic        err_q, err_d;
`else
  logic [7:0]  unused_tmo_cyc;
  assign unused_tmo_cyc = TMO_CYC;
`endif

  assign step      = EN && CE_R;
  assign xfer_done = ibus_req_q && !ibus.IBUS_BUSY;

  always_comb begin
    state_d      = state_q;
    div64_d      = div64_q;
    dvsr_d       = dvsr_q;
    dvdh_d       = dvdh_q;
    dvdl_d       = dvdl_q;
    stage_quot_d = stage_quot_q;
    stage_rem_d  = stage_rem_q;
    quot_d       = quot_q;
    rem_d        = rem_q;
    ovf_d        = ovf_q;
`ifdef DIVINIT_TIMEOUT_EN
    tmo_d        = tmo_q;
    err_d        = err_q;
`endif

    case (state_q)
      StIdle: begin
        if (CMD_VALID) begin
          state_d = StWDvcr;
          div64_d = CMD_DIV64;
          dvsr_d  = CMD_DVSR;
          dvdh_d  = CMD_DVDH;
          dvdl_d  = CMD_DVDL;
        end
      end
      StWDvcr:  if (xfer_done) state_d = StWDvsr;
      StWDvsr:  if (xfer_done) state_d = div64_q ? StWDvdh : StWDvdnt;
      StWDvdh:  if (xfer_done) state_d = StWDvdl;
      StWDvdl:  if (xfer_done) state_d = StRDvdl;
      StWDvdnt: if (xfer_done) state_d = StRDvdl;
      StRDvdl: begin
        if (xfer_done) begin
          state_d      = StRDvdh;
          stage_quot_d = ibus.IBUS_DI;
        end
      end
      StRDvdh: begin
        if (xfer_done) begin
          state_d     = StRDvcr;
          stage_rem_d = ibus.IBUS_DI;
        end
      end
      StRDvcr: begin
        // Results are published together on entry to DONE so RES_* never show a mix.
        if (xfer_done) begin
          state_d = StDone;
          quot_d  = stage_quot_q;
          rem_d   = stage_rem_q;
          ovf_d   = ibus.IBUS_DI[0];
`ifdef DIVINIT_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

`ifdef DIVINIT_TIMEOUT_EN
    if (ibus_req_q) begin
      if (xfer_done) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_CYC - 8'd1) begin
        tmo_d   = '0;
        state_d = StDone;
        quot_d  = '0;
        rem_d   = '0;
        ovf_d   = 1'b0;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + 8'd1;
      end
    end
`endif

    // Bus outputs are a function of the state being entered, so requests run back-to-back.
    ibus_req_d = 1'b1;
    ibus_ba_d  = 4'hF;
    ibus_we_d  = 1'b1;
    ibus_do_d  = '0;
    off_d      = '0;
    case (state_d)
      StWDvcr: begin
        off_d = OffDvcr;
      end
      StWDvsr: begin
        off_d     = OffDvsr;
        ibus_do_d = dvsr_d;
      end
      StWDvdh: begin
        off_d     = OffDvdh;
        ibus_do_d = dvdh_d;
      end
      StWDvdl: begin
        off_d     = OffDvdl;
        ibus_do_d = dvdl_d;
      end
      StWDvdnt: begin
        off_d     = OffDvdnt;
        ibus_do_d = dvdl_d;
      end
      StRDvdl: begin
        off_d     = OffDvdl;
        ibus_we_d = 1'b0;
      end
      StRDvdh: begin
        off_d     = OffDvdh;
        ibus_we_d = 1'b0;
      end
      StRDvcr: begin
        off_d     = OffDvcr;
        ibus_we_d = 1'b0;
      end
      default: begin
        ibus_req_d = 1'b0;
        ibus_ba_d  = 4'h0;
        ibus_we_d  = 1'b0;
      end
    endcase
    ibus_a_d = ibus_req_d ? (DIVU_BASE + {24'h0, off_d}) : 32'h0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= StIdle;
      div64_q      <= 1'b0;
      dvsr_q       <= '0;
      dvdh_q       <= '0;
      dvdl_q       <= '0;
      stage_quot_q <= '0;
      stage_rem_q  <= '0;
      quot_q       <= '0;
      rem_q        <= '0;
      ovf_q        <= 1'b0;
      ibus_a_q     <= '0;
      ibus_do_q    <= '0;
      ibus_ba_q    <= '0;
      ibus_we_q    <= 1'b0;
      ibus_req_q   <= 1'b0;
    end else if (step) begin
      state_q      <= state_d;
      div64_q      <= div64_d;
      dvsr_q       <= dvsr_d;
      dvdh_q       <= dvdh_d;
      dvdl_q       <= dvdl_d;
      stage_quot_q <= stage_quot_d;
      stage_rem_q  <= stage_rem_d;
      quot_q       <= quot_d;
      rem_q        <= rem_d;
      ovf_q        <= ovf_d;
      ibus_a_q     <= ibus_a_d;
      ibus_do_q    <= ibus_do_d;
      ibus_ba_q    <= ibus_ba_d;
      ibus_we_q    <= ibus_we_d;
      ibus_req_q   <= ibus_req_d;
    end
  end

`ifdef DIVINIT_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else if (step) begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign RES_ERR = err_q;
`else
  assign RES_ERR = 1'b0;
`endif

  assign CMD_READY     = (state_q == StIdle);
  assign RES_VALID     = (state_q == StDone);
  assign RES_Q         = quot_q;
  assign RES_R         = rem_q;
  assign RES_OVF       = ovf_q;

  assign ibus.IBUS_A   = ibus_a_q;
  assign ibus.IBUS_DO  = ibus_do_q;
  assign ibus.IBUS_BA  = ibus_ba_q;
  assign ibus.IBUS_WE  = ibus_we_q;
  assign ibus.IBUS_REQ = ibus_req_q;

endmodule

// File: tb/tb_sh7604_div_initiator.sv
// Bench for sh7604_div_initiator: DIVU register responder, result scoreboard, vector table
// and hand sequences for stall, freeze, reset and (when DIVINIT_TIMEOUT_EN) timeout.
module tb_sh7604_div_initiator;
  localparam logic [31:0] Base = 32'hFFFFFF00;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        CE_R = 1'b1;
  logic        CE_F = 1'b1;
  logic        EN = 1'b1;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic        CMD_DIV64 = 1'b0;
  logic [31:0] CMD_DVSR = '0;
  logic [31:0] CMD_DVDH = '0;
  logic [31:0] CMD_DVDL = '0;
  logic        RES_VALID;
  logic [31:0] RES_Q;
  logic [31:0] RES_R;
  logic        RES_OVF;
  logic        RES_ERR;

  sh7604_div_initiator_if ibus ();

  sh7604_div_initiator #(
    .DIVU_BASE(Base),
    .TMO_CYC  (8'd255)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .CE_R     (CE_R),
    .CE_F     (CE_F),
    .EN       (EN),
    .CMD_VALID(CMD_VALID),
    .CMD_READY(CMD_READY),
    .CMD_DIV64(CMD_DIV64),
    .CMD_DVSR (CMD_DVSR),
    .CMD_DVDH (CMD_DVDH),
    .CMD_DVDL (CMD_DVDL),
    .RES_VALID(RES_VALID),
    .RES_Q    (RES_Q),
    .RES_R    (RES_R),
    .RES_OVF  (RES_OVF),
    .RES_ERR  (RES_ERR),
    .ibus     (ibus)
  );

  typedef struct {
    logic        div64;
    logic [31:0] dvsr;
    logic [31:0] dvdh;
    logic [31:0] dvdl;
    logic [31:0] q;
    logic [31:0] r;
    logic        ovf;
    logic        half;
    logic        busy;
  } vec_t;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        ovf;
    logic        err;
  } res_t;

  typedef struct packed {
    logic [31:0] a;
    logic        we;
    logic [31:0] d;
  } xact_t;

  res_t  sb[$];
  xact_t bus_log[$];

  int n_vec = 0;
  int n_fail = 0;

  logic        half = 1'b0;
  logic        ph = 1'b0;
  logic        busy_rand = 1'b0;
  logic        busy_force = 1'b0;
  int          stall_left = 0;
  logic [31:0] r_dvsr = '0, r_dvdh = '0, r_dvdl = '0, r_dvcr = '0;

  initial forever #5 CLK = ~CLK;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic xact_t mk(input logic [31:0] a, input logic we, input logic [31:0] d);
    xact_t x;
    x.a  = a;
    x.we = we;
    x.d  = d;
    return x;
  endfunction

  // Signed divide as the DIVU does it; zero divisor and out-of-range quotient flag OVF.
  task automatic do_divide(input logic [63:0] dvd);
    longint s, d, q, r;
    d = longint'($signed(r_dvsr));
    if (d == 0) begin
      r_dvcr[0] = 1'b1;
      r_dvdl    = '0;
      r_dvdh    = '0;
    end else begin
      s = $signed(dvd);
      q = s / d;
      r = s % d;
      r_dvcr[0] = (q > 64'sd2147483647) || (q < -64'sd2147483648);
      r_dvdl    = q[31:0];
      r_dvdh    = r[31:0];
    end
  endtask

  // CE phases and responder stall, updated just after each rising edge.
  initial forever begin
    @(posedge CLK);
    #1;
    if (half) begin
      ph   = ~ph;
      CE_R = ph;
      CE_F = ~ph;
    end else begin
      CE_R = 1'b1;
      CE_F = 1'b1;
    end
    if (stall_left > 0 && ibus.IBUS_REQ && !ibus.IBUS_WE && ibus.IBUS_A == Base + 32'h14) begin
      ibus.IBUS_BUSY = 1'b1;
      if (CE_R && EN) stall_left--;
    end else begin
      ibus.IBUS_BUSY = busy_force | (busy_rand & 1'($urandom_range(0, 1)));
    end
  end

  // Responder: inputs are stable from here to the next rising edge, so this predicts completion.
  initial begin
    ibus.IBUS_DI = '0;
    forever begin
      @(negedge CLK);
      if (RST_N && EN && CE_R && ibus.IBUS_REQ && !ibus.IBUS_BUSY) begin
        bus_log.push_back(mk(ibus.IBUS_A, ibus.IBUS_WE, ibus.IBUS_WE ? ibus.IBUS_DO : 32'h0));
        if (ibus.IBUS_WE) begin
          case (ibus.IBUS_A - Base)
            32'h00:  r_dvsr = ibus.IBUS_DO;
            32'h04:  do_divide({{32{ibus.IBUS_DO[31]}}, ibus.IBUS_DO});
            32'h08:  r_dvcr = ibus.IBUS_DO;
            32'h10:  r_dvdh = ibus.IBUS_DO;
            32'h14:  do_divide({r_dvdh, ibus.IBUS_DO});
            default: ;
          endcase
        end
      end
      case (ibus.IBUS_A - Base)
        32'h00:  ibus.IBUS_DI = r_dvsr;
        32'h04:  ibus.IBUS_DI = r_dvdl;
        32'h08:  ibus.IBUS_DI = r_dvcr;
        32'h10:  ibus.IBUS_DI = r_dvdh;
        32'h14:  ibus.IBUS_DI = r_dvdl;
        default: ibus.IBUS_DI = 32'hBAD0BAD0;
      endcase
    end
  end

  // Result monitor: one pop per enabled DONE period.
  initial forever begin
    res_t e;
    @(negedge CLK);
    if (RST_N && EN && CE_R && RES_VALID) begin
      if (sb.size() == 0) begin
        check("unexpected_res_valid", 65'(RES_VALID), 65'(0));
      end else begin
        e = sb.pop_front();
        check("res_q", 65'(RES_Q), 65'(e.q));
        check("res_r", 65'(RES_R), 65'(e.r));
        check("res_ovf", 65'(RES_OVF), 65'(e.ovf));
        check("res_err", 65'(RES_ERR), 65'(e.err));
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic run_cmd(input vec_t v, input bit push, input bit err);
    res_t e;
    bit   acc;
    CMD_DIV64 = v.div64;
    CMD_DVSR  = v.dvsr;
    CMD_DVDH  = v.dvdh;
    CMD_DVDL  = v.dvdl;
    CMD_VALID = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = CMD_READY && CE_R && EN;
      step();
    end
    check("cmd_accept", 65'(acc), 65'(1));
    CMD_VALID = 1'b0;
    CMD_DIV64 = ~v.div64;
    CMD_DVSR  = $urandom;
    CMD_DVDH  = $urandom;
    CMD_DVDL  = $urandom;
    if (push) begin
      e.q   = err ? 32'h0 : v.q;
      e.r   = err ? 32'h0 : v.r;
      e.ovf = err ? 1'b0 : v.ovf;
      e.err = err;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) step();
    check("result_pending", 65'(sb.size()), 65'(0));
    step();
    step();
  endtask

  task automatic wait_addr(input logic [31:0] a, input logic we, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (ibus.IBUS_REQ && ibus.IBUS_A == a && ibus.IBUS_WE == we) ok = 1'b1;
      else step();
    end
  endtask

  task automatic check_bus(input vec_t v);
    xact_t exp[$];
    exp.push_back(mk(Base + 32'h08, 1'b1, 32'h0));
    exp.push_back(mk(Base + 32'h00, 1'b1, v.dvsr));
    if (v.div64) begin
      exp.push_back(mk(Base + 32'h10, 1'b1, v.dvdh));
      exp.push_back(mk(Base + 32'h14, 1'b1, v.dvdl));
    end else begin
      exp.push_back(mk(Base + 32'h04, 1'b1, v.dvdl));
    end
    exp.push_back(mk(Base + 32'h14, 1'b0, 32'h0));
    exp.push_back(mk(Base + 32'h10, 1'b0, 32'h0));
    exp.push_back(mk(Base + 32'h08, 1'b0, 32'h0));
    check("bus_len", 65'(bus_log.size()), 65'(exp.size()));
    for (int i = 0; i < exp.size() && i < bus_log.size(); i++)
      check($sformatf("bus_xact%0d", i), 65'(bus_log[i]), 65'(exp[i]));
  endtask

  vec_t vecs[7];

  initial begin
    bit          ok;
    int          bad;
    int          n;
    logic [31:0] last_q;
    logic [31:0] a0, d0;

    //           div64 dvsr          dvdh          dvdl          q             r             ovf  half busy
    vecs[0] = '{1'b0, 32'd7,        32'hDEADBEEF, 32'd100,      32'd14,       32'd2,        1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'd7,        32'h0,        32'hFFFFFF9C, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 32'd2,        32'd1,        32'd0,        32'h80000000, 32'h0,        1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 32'd0,        32'h0,        32'd5,        32'h0,        32'h0,        1'b1, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 32'd10,       32'h0,        32'd1000,     32'd100,      32'd0,        1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF0, 32'd5,        32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 32'hFFFFFFFF, 32'h0,        32'h80000000, 32'h80000000, 32'h0,        1'b1, 1'b0, 1'b0};

    ibus.IBUS_BUSY = 1'b0;
    step();
    step();
    check("rst_req", 65'(ibus.IBUS_REQ), 65'(0));
    check("rst_a", 65'(ibus.IBUS_A), 65'(0));
    check("rst_ba", 65'(ibus.IBUS_BA), 65'(0));
    check("rst_res", 65'({RES_VALID, RES_Q, RES_R, RES_OVF, RES_ERR}), 65'(0));
    RST_N = 1'b1;
    step();
    check("rst_ready", 65'(CMD_READY), 65'(1));
    check("rst_bus_idle", 65'({ibus.IBUS_REQ, ibus.IBUS_WE, ibus.IBUS_DO}), 65'(0));

    foreach (vecs[i]) begin
      half      = vecs[i].half;
      busy_rand = vecs[i].busy;
      bus_log.delete();
      run_cmd(vecs[i], 1'b1, 1'b0);
      check("ready_low_busy", 65'(CMD_READY), 65'(0));
      wait_idle(600);
      check_bus(vecs[i]);
      last_q = vecs[i].q;
    end
    half      = 1'b0;
    busy_rand = 1'b0;
    step();
    step();

    // Responder stalls the DVDL read for 10 cycles.
    stall_left = 10;
    run_cmd(vecs[0], 1'b1, 1'b0);
    wait_addr(Base + 32'h14, 1'b0, 50, ok);
    check("stall_reach", 65'(ok), 65'(1));
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!(ibus.IBUS_REQ && !ibus.IBUS_WE && ibus.IBUS_A == Base + 32'h14 &&
            ibus.IBUS_BA == 4'hF)) bad++;
    end
    check("stall_hold", 65'(bad), 65'(0));
    step();
    check("stall_release", 65'(ibus.IBUS_A), 65'(Base + 32'h10));
    wait_idle(100);
    last_q = vecs[0].q;

    // EN low freezes a held write request and the published results.
    run_cmd(vecs[4], 1'b1, 1'b0);
    wait_addr(Base + 32'h10, 1'b1, 50, ok);
    check("freeze_reach", 65'(ok), 65'(1));
    EN = 1'b0;
    a0 = ibus.IBUS_A;
    d0 = ibus.IBUS_DO;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!(ibus.IBUS_REQ && ibus.IBUS_WE && ibus.IBUS_A == a0 && ibus.IBUS_DO == d0)) bad++;
    end
    check("freeze_hold", 65'(bad), 65'(0));
    check("res_hold", 65'(RES_Q), 65'(last_q));
    EN = 1'b1;
    wait_idle(100);

    // Reset in W_DVSR aborts without a result.
    run_cmd(vecs[0], 1'b0, 1'b0);
    wait_addr(Base + 32'h00, 1'b1, 50, ok);
    check("rst_mid_reach", 65'(ok), 65'(1));
    RST_N = 1'b0;
    #1;
    check("rst_mid_req", 65'(ibus.IBUS_REQ), 65'(0));
    check("rst_mid_a", 65'(ibus.IBUS_A), 65'(0));
    check("rst_mid_ready", 65'(CMD_READY), 65'(1));
    check("rst_mid_res", 65'({RES_VALID, RES_Q}), 65'(0));
    step();
    RST_N = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("rst_mid_idle", 65'({CMD_READY, ibus.IBUS_REQ}), 65'(2'b10));

`ifdef DIVINIT_TIMEOUT_EN
    // Stuck responder: request drops after TMO_CYC busy cycles with RES_ERR.
    busy_force = 1'b1;
    run_cmd(vecs[0], 1'b1, 1'b1);
    n = 0;
    while (ibus.IBUS_REQ && n < 400) begin
      step();
      n++;
    end
    check("tmo_cycles", 65'(n), 65'(255));
    check("tmo_req", 65'(ibus.IBUS_REQ), 65'(0));
    busy_force = 1'b0;
    wait_idle(20);
    check("tmo_ready", 65'(CMD_READY), 65'(1));
`else
    n = 0;
`endif

    check("sb_drained", 65'(sb.size()), 65'(n * 0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
